// File: rtl/plic_core_lite_if.sv
// Interrupt-line, configuration and claim/complete bundle for plic_core_lite.
// slave is the controller side, master is the driver (shim, core, bench).
interface plic_core_lite_if #(
    parameter int NUM_SOURCES = 32,
    parameter int PRIO_WIDTH  = 3,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) ();
    logic [NUM_SOURCES-1:0] irq_src_i;
    logic                   cfg_valid_i;
    logic [1:0]             cfg_sel_i;
    logic [ID_WIDTH-1:0]    cfg_idx_i;
    logic [PRIO_WIDTH-1:0]  cfg_data_i;
    logic                   claim_req_i;
    logic                   claim_valid_o;
    logic [ID_WIDTH-1:0]    claim_id_o;
    logic                   complete_valid_i;
    logic [ID_WIDTH-1:0]    complete_id_i;
    logic                   ext_irq_o;
    logic [NUM_SOURCES-1:0] pending_o;

    modport slave (
        input  irq_src_i, cfg_valid_i, cfg_sel_i, cfg_idx_i, cfg_data_i,
               claim_req_i, complete_valid_i, complete_id_i,
        output claim_valid_o, claim_id_o, ext_irq_o, pending_o
    );

    modport master (
        output irq_src_i, cfg_valid_i, cfg_sel_i, cfg_idx_i, cfg_data_i,
               claim_req_i, complete_valid_i, complete_id_i,
        input  claim_valid_o, claim_id_o, ext_irq_o, pending_o
    );
endinterface

// File: rtl/plic_core_lite.sv
// Single-hart PLIC: gateways, registered max-priority arbiter, claim/complete; edge mode under PLIC_EDGE_TRIGGER_EN.
// Latency: level line -> pending 1 clk, -> best 2 clks, -> ext_irq_o 3 clks; claim response 1 clk after request.
// No backpressure: config, claim and complete strobes are accepted every cycle.
module plic_core_lite #(
    parameter int NUM_SOURCES = 32,
    parameter int PRIO_WIDTH  = 3,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    plic_core_lite_if.slave  bus
);
    localparam logic [1:0] SEL_PRIO   = 2'd0;
    localparam logic [1:0] SEL_EN     = 2'd1;
    localparam logic [1:0] SEL_THRESH = 2'd2;
    localparam logic [1:0] SEL_EDGE   = 2'd3;

    logic [PRIO_WIDTH-1:0]  r_prio [NUM_SOURCES];
    logic [NUM_SOURCES-1:0] r_en;
    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] r_in_service;
    logic [PRIO_WIDTH-1:0]  r_thresh;
    logic [ID_WIDTH-1:0]    r_best_id;
    logic [PRIO_WIDTH-1:0]  r_best_prio;
    logic                   r_claim_vld;
    logic [ID_WIDTH-1:0]    r_claim_id;
    logic                   r_ext_irq;

    logic                   w_idx_ok;
    logic                   w_claim_hit;
    logic [NUM_SOURCES-1:0] w_claim_mask;
    logic [NUM_SOURCES-1:0] w_done_mask;
    logic [NUM_SOURCES-1:0] w_set;
    logic [NUM_SOURCES-1:0] w_pending_nxt;
    logic [NUM_SOURCES-1:0] w_in_service_nxt;
    logic [NUM_SOURCES-1:0] w_arb_pend;
    logic [ID_WIDTH-1:0]    w_best_id;
    logic [PRIO_WIDTH-1:0]  w_best_prio;

`ifdef PLIC_EDGE_TRIGGER_EN
    logic [NUM_SOURCES-1:0] r_edge_mode;
    logic [NUM_SOURCES-1:0] r_irq_prev;
    logic [NUM_SOURCES-1:0] r_edge_q;
    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_edge_q_nxt;
`endif

    assign w_idx_ok     = (bus.cfg_idx_i != '0) && (int'(bus.cfg_idx_i) < NUM_SOURCES);
    assign w_claim_hit  = bus.claim_req_i && (r_best_prio != '0);
    assign w_claim_mask = w_claim_hit ? (NUM_SOURCES'(1) << r_best_id) : '0;
    assign w_done_mask  = bus.complete_valid_i ?
                          ((NUM_SOURCES'(1) << bus.complete_id_i) & r_in_service) : '0;

    always_comb begin
        w_set = '0;
`ifdef PLIC_EDGE_TRIGGER_EN
        w_rise       = bus.irq_src_i & ~r_irq_prev;
        w_edge_q_nxt = r_edge_q;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (r_edge_mode[i]) begin
                // Edges seen while busy collapse into one deferred request.
                if (!r_pending[i] && !r_in_service[i]) begin
                    if (w_rise[i] || r_edge_q[i]) begin
                        w_set[i]        = 1'b1;
                        w_edge_q_nxt[i] = 1'b0;
                    end
                end else if (w_rise[i]) begin
                    w_edge_q_nxt[i] = 1'b1;
                end
            end else begin
                w_set[i]        = bus.irq_src_i[i] && !r_pending[i] && !r_in_service[i];
                w_edge_q_nxt[i] = 1'b0;
            end
        end
        w_edge_q_nxt[0] = 1'b0;
`else
        w_set = bus.irq_src_i & ~r_pending & ~r_in_service;
`endif
        w_set[0] = 1'b0;
    end

    assign w_pending_nxt    = (r_pending | w_set) & ~w_claim_mask;
    assign w_in_service_nxt = (r_in_service & ~w_done_mask) | w_claim_mask;

    // A source claimed this cycle is hidden so a back-to-back claim never sees it again.
    assign w_arb_pend = r_pending & ~w_claim_mask & r_en;

    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (w_arb_pend[i] && (r_prio[i] > w_best_prio)) begin
                w_best_prio = r_prio[i];
                w_best_id   = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                r_prio[i] <= '0;
            end
            r_en     <= '0;
            r_thresh <= '0;
`ifdef PLIC_EDGE_TRIGGER_EN
            r_edge_mode <= '0;
`endif
        end else if (bus.cfg_valid_i) begin
            if (bus.cfg_sel_i == SEL_THRESH) begin
                r_thresh <= bus.cfg_data_i;
            end else if (w_idx_ok) begin
                if (bus.cfg_sel_i == SEL_PRIO) begin
                    r_prio[bus.cfg_idx_i] <= bus.cfg_data_i;
                end else if (bus.cfg_sel_i == SEL_EN) begin
                    r_en[bus.cfg_idx_i] <= bus.cfg_data_i[0];
                end
`ifdef PLIC_EDGE_TRIGGER_EN
                else if (bus.cfg_sel_i == SEL_EDGE) begin
                    r_edge_mode[bus.cfg_idx_i] <= bus.cfg_data_i[0];
                end
`endif
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_best_id    <= '0;
            r_best_prio  <= '0;
            r_claim_vld  <= 1'b0;
            r_claim_id   <= '0;
            r_ext_irq    <= 1'b0;
`ifdef PLIC_EDGE_TRIGGER_EN
            r_irq_prev   <= '0;
            r_edge_q     <= '0;
`endif
        end else begin
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
            r_best_id    <= w_best_id;
            r_best_prio  <= w_best_prio;
            r_ext_irq    <= (r_best_prio > r_thresh);
            r_claim_vld  <= bus.claim_req_i;
            if (bus.claim_req_i) begin
                r_claim_id <= w_claim_hit ? r_best_id : '0;
            end
`ifdef PLIC_EDGE_TRIGGER_EN
            r_irq_prev   <= bus.irq_src_i;
            r_edge_q     <= w_edge_q_nxt;
`endif
        end
    end

    assign bus.claim_valid_o = r_claim_vld;
    assign bus.claim_id_o    = r_claim_id;
    assign bus.ext_irq_o     = r_ext_irq;
    assign bus.pending_o     = r_pending;

    logic w_unused;
    assign w_unused = ^{SEL_PRIO, SEL_EN, SEL_EDGE};
endmodule

// File: tb/tb_plic_core_lite.sv
// Bench for plic_core_lite: directed scenarios plus randomized rounds against a priority-order model.
module tb_plic_core_lite;
    localparam int NS = 6;
    localparam int PW = 3;
    localparam int IW = 3;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    plic_core_lite_if #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) bus ();

    plic_core_lite #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Spec-level model state for the randomized rounds.
    int m_prio [NS];
    bit m_en   [NS];
    bit m_pend [NS];
    bit m_isv  [NS];
    int m_thr;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.irq_src_i = '0; bus.cfg_valid_i = 1'b0; bus.cfg_sel_i = '0;
        bus.cfg_idx_i = '0; bus.cfg_data_i = '0; bus.claim_req_i = 1'b0;
        bus.complete_valid_i = 1'b0; bus.complete_id_i = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic cfg(input int sel, input int idx, input int data);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_sel_i   = 2'(sel);
        bus.cfg_idx_i   = IW'(idx);
        bus.cfg_data_i  = PW'(data);
        tick();
        bus.cfg_valid_i = 1'b0;
    endtask

    task automatic claim(output logic vld, output int id);
        bus.claim_req_i = 1'b1;
        tick();
        bus.claim_req_i = 1'b0;
        vld = bus.claim_valid_o;
        id  = int'(bus.claim_id_o);
    endtask

    task automatic complete(input int id);
        bus.complete_valid_i = 1'b1;
        bus.complete_id_i    = IW'(id);
        tick();
        bus.complete_valid_i = 1'b0;
    endtask

    // Highest priority first, lowest id within a priority level; 0 if nothing eligible.
    function automatic int model_best();
        for (int p = (1 << PW) - 1; p >= 1; p--)
            for (int i = 1; i < NS; i++)
                if (m_pend[i] && m_en[i] && m_prio[i] == p) return i;
        return 0;
    endfunction

    function automatic logic [NS-1:0] model_pend_vec();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic test_reset();
        logic vld; int id;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.pending_o !== '0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", bus.pending_o); end
        n_checks++; if (bus.ext_irq_o !== 1'b0 || bus.claim_valid_o !== 1'b0 || bus.claim_id_o !== '0) begin
            n_fail++; $display("FAIL reset_outputs: ext=%b vld=%b id=%0d want 0", bus.ext_irq_o, bus.claim_valid_o, bus.claim_id_o); end
        do_reset();
        cfg(0, 2, 1); cfg(1, 2, 1); cfg(0, 4, 3); cfg(1, 4, 1);
        bus.irq_src_i = NS'(1 << 2);
        repeat (4) tick();
        claim(vld, id);
        n_checks++; if (id !== 2) begin n_fail++; $display("FAIL reset_setup_claim: got %0d want 2", id); end
        bus.irq_src_i = NS'((1 << 2) | (1 << 4));
        repeat (4) tick();
        n_checks++; if (bus.pending_o !== NS'(1 << 4) || bus.ext_irq_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_preop: pend=%b ext=%b want 010000/1", bus.pending_o, bus.ext_irq_o); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.pending_o !== '0 || bus.ext_irq_o !== 1'b0 || bus.claim_id_o !== '0 || bus.claim_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: pend=%b ext=%b id=%0d vld=%b want all 0", bus.pending_o, bus.ext_irq_o, bus.claim_id_o, bus.claim_valid_o); end
        #2 reset = 1'b0;
        tick();
        n_checks++; if (bus.pending_o !== NS'((1 << 2) | (1 << 4))) begin
            n_fail++; $display("FAIL reset_release_pend: got %b want 010100", bus.pending_o); end
    endtask

    task automatic test_level();
        logic vld; int id;
        do_reset();
        cfg(0, 4, 5); cfg(1, 4, 1); cfg(2, 0, 0);
        bus.irq_src_i = NS'(1 << 4);
        tick(); tick();
        n_checks++; if (bus.ext_irq_o !== 1'b0) begin n_fail++; $display("FAIL level_ext_early: got %b want 0", bus.ext_irq_o); end
        tick();
        n_checks++; if (bus.ext_irq_o !== 1'b1) begin n_fail++; $display("FAIL level_ext_3clk: got %b want 1", bus.ext_irq_o); end
        claim(vld, id);
        n_checks++; if (vld !== 1'b1 || id !== 4 || bus.pending_o[4] !== 1'b0 || bus.ext_irq_o !== 1'b1) begin
            n_fail++; $display("FAIL level_claim: vld=%b id=%0d pend4=%b ext=%b want 1/4/0/1", vld, id, bus.pending_o[4], bus.ext_irq_o); end
        tick();
        n_checks++; if (bus.ext_irq_o !== 1'b0 || bus.claim_valid_o !== 1'b0 || bus.claim_id_o !== IW'(4)) begin
            n_fail++; $display("FAIL level_ext_drop: ext=%b vld=%b id=%0d want 0/0/4", bus.ext_irq_o, bus.claim_valid_o, bus.claim_id_o); end
        complete(4);
        n_checks++; if (bus.pending_o[4] !== 1'b0) begin n_fail++; $display("FAIL level_complete_early: got %b want 0", bus.pending_o[4]); end
        tick();
        n_checks++; if (bus.pending_o[4] !== 1'b1) begin n_fail++; $display("FAIL level_repend: got %b want 1", bus.pending_o[4]); end
    endtask

    task automatic test_arbitration();
        logic vld; int id;
        int exp_ids [4] = '{2, 3, 1, 0};
        do_reset();
        cfg(0, 1, 3); cfg(0, 3, 6); cfg(0, 2, 6);
        cfg(1, 1, 1); cfg(1, 2, 1); cfg(1, 3, 1);
        bus.irq_src_i = NS'(6'b001110);
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            claim(vld, id);
            n_checks++; if (vld !== 1'b1 || id !== exp_ids[k]) begin
                n_fail++; $display("FAIL arb_claim%0d: vld=%b id=%0d want 1/%0d", k, vld, id, exp_ids[k]); end
            tick(); tick();
        end
    endtask

    task automatic test_back_to_back();
        int exp_ids [4] = '{2, 3, 1, 0};
        do_reset();
        cfg(0, 1, 3); cfg(0, 3, 6); cfg(0, 2, 6);
        cfg(1, 1, 1); cfg(1, 2, 1); cfg(1, 3, 1);
        bus.irq_src_i = NS'(6'b001110);
        repeat (4) tick();
        bus.claim_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) bus.claim_req_i = 1'b0;
            n_checks++; if (bus.claim_valid_o !== 1'b1 || int'(bus.claim_id_o) !== exp_ids[k]) begin
                n_fail++; $display("FAIL b2b_claim%0d: vld=%b id=%0d want 1/%0d", k, bus.claim_valid_o, bus.claim_id_o, exp_ids[k]); end
        end
    endtask

    task automatic test_threshold();
        logic vld; int id;
        do_reset();
        cfg(0, 2, 2); cfg(1, 2, 1); cfg(2, 0, 2);
        bus.irq_src_i = NS'(1 << 2);
        repeat (4) tick();
        n_checks++; if (bus.ext_irq_o !== 1'b0) begin n_fail++; $display("FAIL thr_equal: got %b want 0", bus.ext_irq_o); end
        cfg(2, 3, 1);
        n_checks++; if (bus.ext_irq_o !== 1'b0) begin n_fail++; $display("FAIL thr_early: got %b want 0", bus.ext_irq_o); end
        tick();
        n_checks++; if (bus.ext_irq_o !== 1'b1) begin n_fail++; $display("FAIL thr_lowered: got %b want 1", bus.ext_irq_o); end
        cfg(2, 0, 2);
        tick(); tick();
        claim(vld, id);
        n_checks++; if (vld !== 1'b1 || id !== 2 || bus.ext_irq_o !== 1'b0) begin
            n_fail++; $display("FAIL thr_claim: vld=%b id=%0d ext=%b want 1/2/0", vld, id, bus.ext_irq_o); end
    endtask

`ifdef PLIC_EDGE_TRIGGER_EN
    task automatic test_edge();
        logic vld; int id;
        do_reset();
        cfg(0, 3, 4); cfg(1, 3, 1); cfg(3, 3, 1);
        bus.irq_src_i = NS'(1 << 3); tick();
        bus.irq_src_i = '0; tick(); tick(); tick();
        n_checks++; if (bus.pending_o !== NS'(1 << 3)) begin n_fail++; $display("FAIL edge_first: got %b want 001000", bus.pending_o); end
        claim(vld, id);
        n_checks++; if (id !== 3) begin n_fail++; $display("FAIL edge_claim: got %0d want 3", id); end
        for (int k = 0; k < 2; k++) begin
            bus.irq_src_i = NS'(1 << 3); tick();
            bus.irq_src_i = '0; tick();
        end
        complete(5);
        tick();
        n_checks++; if (bus.pending_o !== '0) begin n_fail++; $display("FAIL edge_busy: got %b want 0", bus.pending_o); end
        complete(3);
        n_checks++; if (bus.pending_o[3] !== 1'b0) begin n_fail++; $display("FAIL edge_promote_early: got %b want 0", bus.pending_o[3]); end
        tick();
        n_checks++; if (bus.pending_o[3] !== 1'b1) begin n_fail++; $display("FAIL edge_promote: got %b want 1", bus.pending_o[3]); end
        tick();
        claim(vld, id);
        complete(3);
        repeat (3) tick();
        n_checks++; if (id !== 3 || bus.pending_o !== '0) begin
            n_fail++; $display("FAIL edge_merge: id=%0d pend=%b want 3/0", id, bus.pending_o); end
    endtask
`endif

    task automatic test_config_guard();
        logic vld; int id;
        do_reset();
        cfg(0, 0, 7); cfg(1, 0, 1);
        cfg(0, NS, 7); cfg(1, NS, 1); cfg(0, NS + 1, 7); cfg(1, NS + 1, 1);
        bus.irq_src_i = NS'(1);
        repeat (4) tick();
        n_checks++; if (bus.pending_o !== '0 || bus.ext_irq_o !== 1'b0) begin
            n_fail++; $display("FAIL guard_src0: pend=%b ext=%b want 0/0", bus.pending_o, bus.ext_irq_o); end
        claim(vld, id);
        n_checks++; if (vld !== 1'b1 || id !== 0) begin n_fail++; $display("FAIL guard_claim: vld=%b id=%0d want 1/0", vld, id); end
        cfg(0, 1, 5); cfg(1, 1, 1);
        bus.irq_src_i = NS'(6'b000011);
        repeat (4) tick();
        n_checks++; if (bus.ext_irq_o !== 1'b1 || bus.pending_o !== NS'(6'b000010)) begin
            n_fail++; $display("FAIL guard_src1: ext=%b pend=%b want 1/000010", bus.ext_irq_o, bus.pending_o); end
        cfg(2, 0, 7);
        tick();
        n_checks++; if (bus.ext_irq_o !== 1'b0) begin n_fail++; $display("FAIL guard_thr_idx0: got %b want 0", bus.ext_irq_o); end
    endtask

    task automatic test_random();
        int q[$];
        int b;
        logic [NS-1:0] lines;
        do_reset();
        for (int i = 0; i < NS; i++) begin m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_isv[i] = 0; end
        m_thr = 0;
        for (int r = 0; r < 20; r++) begin
            lines = NS'($urandom);
            bus.irq_src_i = lines;
            for (int i = 1; i < NS; i++) begin
                m_prio[i] = $urandom_range(0, 7); m_en[i] = 1'($urandom_range(0, 1));
                cfg(0, i, m_prio[i]); cfg(1, i, int'(m_en[i]));
            end
            m_thr = $urandom_range(0, 4);
            cfg(2, 0, m_thr);
            for (int i = 1; i < NS; i++)
                if (m_isv[i]) begin complete(i); m_isv[i] = 0; end
            repeat (4) tick();
            for (int i = 1; i < NS; i++) if (lines[i]) m_pend[i] = 1;
            b = model_best();
            n_checks++; if (bus.pending_o !== model_pend_vec() || bus.ext_irq_o !== (b != 0 && m_prio[b] > m_thr)) begin
                n_fail++; $display("FAIL rand%0d_state: pend=%b ext=%b want %b/%b", r, bus.pending_o, bus.ext_irq_o, model_pend_vec(), (b != 0 && m_prio[b] > m_thr)); end
            q.delete();
            do begin
                b = model_best();
                q.push_back(b);
                if (b != 0) begin m_pend[b] = 0; m_isv[b] = 1; end
            end while (b != 0);
            bus.claim_req_i = 1'b1;
            for (int k = 0; k < q.size(); k++) begin
                tick();
                if (k == q.size() - 1) bus.claim_req_i = 1'b0;
                n_checks++; if (bus.claim_valid_o !== 1'b1 || int'(bus.claim_id_o) !== q[k]) begin
                    n_fail++; $display("FAIL rand%0d_claim%0d: vld=%b id=%0d want 1/%0d", r, k, bus.claim_valid_o, bus.claim_id_o, q[k]); end
            end
            tick();
            n_checks++; if (bus.pending_o !== model_pend_vec()) begin
                n_fail++; $display("FAIL rand%0d_after: pend=%b want %b", r, bus.pending_o, model_pend_vec()); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.irq_src_i = '0; bus.cfg_valid_i = 1'b0; bus.cfg_sel_i = '0;
        bus.cfg_idx_i = '0; bus.cfg_data_i = '0; bus.claim_req_i = 1'b0;
        bus.complete_valid_i = 1'b0; bus.complete_id_i = '0;
        test_reset();
        test_level();
        test_arbitration();
        test_back_to_back();
        test_threshold();
`ifdef PLIC_EDGE_TRIGGER_EN
        test_edge();
`endif
        test_config_guard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
